// File: rtl/ks_note_sequencer.sv
// Note sequencer for the Karplus-Strong voice: walks a (period, duration) table,
// presenting each period to ks_string with a timed pluck at a divided tempo.
module ks_note_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned TEMPO_WIDTH = 16,
  parameter int unsigned PLUCK_LEN   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tbl_wr_en_i,
  input  logic [$clog2(NUM_STEPS)-1:0] tbl_addr_i,
  input  logic [2*DATA_WIDTH-1:0]      tbl_wr_data_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         loop_en_i,
  input  logic [$clog2(NUM_STEPS):0]   num_steps_i,
  input  logic [TEMPO_WIDTH-1:0]       tempo_div_i,
  output logic [DATA_WIDTH-1:0]        period_o,
  output logic                         pluck_o,
  output logic                         busy_o,
  output logic [$clog2(NUM_STEPS)-1:0] step_o,
  output logic                         done_o
);
  localparam int unsigned AW = $clog2(NUM_STEPS);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned PW = $clog2(PLUCK_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           step_q, step_d;
  logic [DATA_WIDTH-1:0]   dur_q, dur_d;
  logic [TEMPO_WIDTH-1:0]  pre_q, pre_d;
  logic [DATA_WIDTH-1:0]   tick_q, tick_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0]   period_q, period_d;
  logic                    pluck_q, pluck_d;
  logic                    done_q, done_d;

  logic [2*DATA_WIDTH-1:0] tbl_q [NUM_STEPS];
  logic [2*DATA_WIDTH-1:0] entry;
  logic [DATA_WIDTH-1:0]   entry_p, entry_d;
  logic [NW-1:0]           n_eff, n_last;
  logic                    tick_done, step_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
    end else if (tbl_wr_en_i) begin
      tbl_q[tbl_addr_i] <= tbl_wr_data_i;
    end
  end

  always_comb begin
    entry   = tbl_q[step_q];
    entry_p = entry[DATA_WIDTH-1:0];
    entry_d = entry[2*DATA_WIDTH-1:DATA_WIDTH];
    n_eff   = (num_steps_i == '0 || num_steps_i > NW'(NUM_STEPS)) ? NW'(NUM_STEPS) : num_steps_i;
    n_last  = n_eff - 1'b1;
    // >= lets a lowered tempo take effect at the very next compare
    tick_done = (pre_q >= tempo_div_i);
    // dur_q holds D-1 (D=0 treated as 1), so the D-th tick is tick_q == dur_q
    step_end  = tick_done && (tick_q >= dur_q);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dur_d    = dur_q;
    pre_d    = pre_q;
    tick_d   = tick_q;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    pluck_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = S_LOAD;
          step_d  = '0;
        end
      end
      S_LOAD: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PLAY;
          dur_d   = (entry_d == '0) ? '0 : entry_d - 1'b1;
          pre_d   = '0;
          tick_d  = '0;
          pcnt_d  = '0;
          if (entry_p != '0) begin
            period_d = entry_p;
            pluck_d  = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (pcnt_q != PW'(PLUCK_LEN)) pcnt_d = pcnt_q + 1'b1;
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (step_end) begin
          if ({1'b0, step_q} < n_last) begin
            step_d  = step_q + 1'b1;
            state_d = S_LOAD;
          end else if (loop_en_i) begin
            step_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          pluck_d = pluck_q && (pcnt_q < PW'(PLUCK_LEN - 1));
          if (tick_done) begin
            pre_d  = '0;
            tick_d = tick_q + 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      dur_q    <= '0;
      pre_q    <= '0;
      tick_q   <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      pluck_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pluck_q  <= pluck_d;
      done_q   <= done_d;
    end
  end

  assign period_o = period_q;
  assign pluck_o  = pluck_q;
  assign busy_o   = (state_q != S_IDLE);
  assign step_o   = step_q;
  assign done_o   = done_q;

endmodule

// File: doc/ks_note_sequencer.md
# ks_note_sequencer

Autonomous note sequencer that drives the Karplus-Strong string voice: it steps through a small table of (period, duration) entries, presents each period to the string's `period_i` and issues a timed pluck pulse, with tempo set by a programmable tick divider. It sits between the SPI register map, which supplies table writes and control bits, and `ks_string`, which consumes `period_o`/`pluck_o`. It runs in the same clock domain as `ks_string`.

## Interface
- `DATA_WIDTH`, 8: width of period and duration fields.
- `NUM_STEPS`, 8: table depth. Power of two, minimum 2.
- `TEMPO_WIDTH`, 16: width of the tempo divider.
- `PLUCK_LEN`, 4: pluck pulse length in clocks. Minimum 1.
- `clk_i`  in  1  single clock, same domain as `ks_string`.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `tbl_wr_en_i`  in  1  table write strobe, one entry per cycle.
- `tbl_addr_i`  in  $clog2(NUM_STEPS)  table write address.
- `tbl_wr_data_i`  in  2*DATA_WIDTH  entry layout: duration in the upper byte, period in the lower byte.
- `start_i`  in  1  level; sampled only in IDLE.
- `stop_i`  in  1  level; abort from any state.
- `loop_en_i`  in  1  wrap to step 0 after the last step instead of finishing.
- `num_steps_i`  in  $clog2(NUM_STEPS)+1  active steps. 0 and values above NUM_STEPS are treated as NUM_STEPS.
- `tempo_div_i`  in  TEMPO_WIDTH  T: one tick is T+1 clocks.
- `period_o`  out  DATA_WIDTH  period to `ks_string`, registered.
- `pluck_o`  out  1  pluck to `ks_string`, registered.
- `busy_o`  out  1  high in LOAD/PLAY.
- `step_o`  out  $clog2(NUM_STEPS)  index of the current step.
- `done_o`  out  1  one-cycle pulse on a non-loop finish.

## Operation
- Table: NUM_STEPS x 2*DATA_WIDTH flops, all cleared to 0 by reset.
  - Writes are accepted in any state.
  - A write to the step currently playing takes effect the next time that step is loaded.
- Entry fields: period P, duration D.
  - P = 0 is a rest: no pluck, and `period_o` holds its previous value.
  - D = 0 is treated as D = 1.
- FSM states: IDLE, LOAD, PLAY.
- IDLE → LOAD when `start_i` = 1 and `stop_i` = 0. Step index is cleared to 0 on this transition.
- LOAD, always exactly 1 cycle:
  - latch table[step] into the P/D working registers;
  - clear the tick and prescale counters;
  - `pluck_o` = 0;
  - go to PLAY.
- PLAY entry, first cycle:
  - if P ≠ 0: `period_o` ← P and `pluck_o` ← 1;
  - the pluck counter runs in parallel with the tick counter;
  - `pluck_o` drops after PLUCK_LEN cycles or at step end, whichever comes first.
- PLAY counting:
  - the prescaler counts 0..T; each wrap is one tick;
  - the step ends on the cycle the D-th tick completes.
- Step end:
  - if step < N-1: step+1, go to LOAD;
  - else if `loop_en_i`: step ← 0, go to LOAD;
  - else: `done_o` pulses, go to IDLE.
- `stop_i` = 1 in LOAD or PLAY → IDLE on the next edge.
  - `pluck_o` ← 0 and `period_o` holds.
  - `done_o` is not pulsed and the step index is retained.
  - `stop_i` wins over a simultaneous `start_i` or step end.
- `start_i` while busy is ignored. A held `start_i` in IDLE restarts immediately after a non-loop finish.
- `num_steps_i`, `tempo_div_i` and `loop_en_i` are sampled live:
  - a tempo change affects the current step at the next prescaler compare;
  - lowering N below the current step ends the sequence at the next step end, following the normal last-step rule.

## Timing
- Reset values:
  - `period_o` = 0;
  - `pluck_o` = 0;
  - `busy_o` = 0;
  - `step_o` = 0;
  - `done_o` = 0;
  - FSM = IDLE;
  - all counters 0.
- `start_i` high at edge k → LOAD during cycle k+1, and `busy_o` = 1 from k+1.
- `period_o` and `pluck_o` update at edge k+2.
- Step duration, LOAD to next LOAD, is exactly 1 + D·(T+1) clocks.
- `pluck_o` width is min(PLUCK_LEN, D·(T+1)). There is always at least one low cycle (LOAD) between consecutive plucks.
- `done_o` is high for exactly the first IDLE cycle. `busy_o` is low in that same cycle.
- Asserting reset mid-operation returns all outputs to their reset values asynchronously, and clears the table.

## Test plan
- T=3, D=2, P=40 at step 0, N=1, loop off, start pulse → `period_o`=40 and `pluck_o` high 4 cycles from edge k+2; `done_o` pulses at edge k+10; `busy_o` high for 9 cycles.
- N=3 with P={30,0,50}, D=1, T=0, loop off → plucks at steps 0 and 2 only; `period_o` stays 30 through step 1; LOAD-to-LOAD spacing is 2 clocks.
- Loop on, N=2 → `step_o` sequence 0,1,0,1,…; `done_o` never asserts; `stop_i` mid-PLAY gives IDLE next edge with `pluck_o`=0, `period_o` held and no `done_o`.
- D=0, T=0, PLUCK_LEN=4 → step lasts 2 clocks; `pluck_o` is truncated to 1 cycle, then low for the LOAD cycle.
- Table write to the playing step during PLAY → current note unchanged, new value heard on the next loop pass; `start_i` and `stop_i` together in IDLE → stays IDLE.
- Async `rst_ni` low mid-pluck → all outputs 0 immediately; table reads back as rests, so restarting produces no pluck.
